// File: rtl/qtu_fmb.sv
// qtu_fmb: neighbor Q-table update and next-hop selection for an EER-RL cluster-routing node.
// Build option: define QTU_FMB_HOPFILTER_EN to admit only entries closer to the CH (or the CH itself) as next hops.
module qtu_fmb #(
  parameter int WORD_WIDTH  = 16,
  parameter int TABLE_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  iAmDestination,
  input  logic                  HB_Reset,
  input  logic [WORD_WIDTH-1:0] fSourceID,
  input  logic [WORD_WIDTH-1:0] fSourceHops,
  input  logic [WORD_WIDTH-1:0] fQValue,
  input  logic [WORD_WIDTH-1:0] fEnergyLeft,
  input  logic [WORD_WIDTH-1:0] fHopsFromCH,
  input  logic [WORD_WIDTH-1:0] fChosenCH,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] hopsFromCH,
  input  logic [WORD_WIDTH-1:0] myQValue,
  output logic [WORD_WIDTH-1:0] nodeID,
  output logic [WORD_WIDTH-1:0] nodeHops,
  output logic [WORD_WIDTH-1:0] nodeEnergy,
  output logic [WORD_WIDTH-1:0] nodeQValue,
  output logic [4:0]            neighborIndex,
  output logic [WORD_WIDTH-1:0] chosenHop,
  output logic                  QTUFMB_done
);

  localparam int IDX_W = 5;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CLEAR  = 3'd1;
  localparam logic [2:0] WRITE  = 3'd2;
  localparam logic [2:0] SELECT = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]             state_r;
  logic [5:0]             clrCnt_r;
  logic [TABLE_DEPTH-1:0] valid_r;

  logic [WORD_WIDTH-1:0] tabId_r     [TABLE_DEPTH];
  logic [WORD_WIDTH-1:0] tabHops_r   [TABLE_DEPTH];
  logic [WORD_WIDTH-1:0] tabEnergy_r [TABLE_DEPTH];
  logic [WORD_WIDTH-1:0] tabQ_r      [TABLE_DEPTH];

  logic [WORD_WIDTH-1:0] fSrcId_r, fSrcHops_r, fQ_r, fEnergy_r, fHops_r, fChosenCh_r, myQ_r;

  logic [WORD_WIDTH-1:0] nodeId_r, nodeHops_r, nodeEnergy_r, nodeQ_r, chosenHop_r;
  logic [IDX_W-1:0]      nbrIdx_r;
  logic                  done_r;

  logic                  take_s;
  logic                  accept_s;
  logic                  hitFound_s, freeFound_s;
  logic [IDX_W-1:0]      hitIdx_s, freeIdx_s, minIdx_s, wrIdx_s;
  logic [WORD_WIDTH-1:0] minQ_s;

  logic [TABLE_DEPTH-1:0] cand_s;
  logic                  bestFound_s, chFound_s;
  logic [IDX_W-1:0]      bestIdx_s;
  logic [WORD_WIDTH-1:0] bestQ_s, bestHops_s, selHop_s;

  assign take_s   = en && !HB_Reset && ((state_r == IDLE) || (state_r == DONE));
  assign accept_s = (fChosenCh_r == chosenCH) || (fSrcId_r == chosenCH);

  // Write-slot lookup: hit entry, else lowest free slot, else lowest-Q victim.
  always_comb begin
    hitFound_s  = 1'b0;
    hitIdx_s    = {IDX_W{1'b0}};
    freeFound_s = 1'b0;
    freeIdx_s   = {IDX_W{1'b0}};
    minIdx_s    = {IDX_W{1'b0}};
    minQ_s      = tabQ_r[0];
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (valid_r[i] && (tabId_r[i] == fSrcId_r)) begin
        hitFound_s = 1'b1;
        hitIdx_s   = IDX_W'(i);
      end else begin
      end
      if (!valid_r[i]) begin
        freeFound_s = 1'b1;
        freeIdx_s   = IDX_W'(i);
      end else begin
      end
    end
    for (int i = 1; i < TABLE_DEPTH; i++) begin
      if (tabQ_r[i] < minQ_s) begin
        minQ_s   = tabQ_r[i];
        minIdx_s = IDX_W'(i);
      end else begin
      end
    end
    if (hitFound_s) begin
      wrIdx_s = hitIdx_s;
    end else if (freeFound_s) begin
      wrIdx_s = freeIdx_s;
    end else begin
      wrIdx_s = minIdx_s;
    end
  end

  // Candidate qualification for next-hop selection.
  always_comb begin
    cand_s = {TABLE_DEPTH{1'b0}};
    for (int i = 0; i < TABLE_DEPTH; i++) begin
`ifdef QTU_FMB_HOPFILTER_EN
      cand_s[i] = valid_r[i] && ((tabHops_r[i] < hopsFromCH) || (tabId_r[i] == chosenCH));
`else
      cand_s[i] = valid_r[i];
`endif
    end
  end

  // Best-Q search; ties go to fewer hops, then the lower index; a direct CH link overrides.
  always_comb begin
    bestFound_s = 1'b0;
    chFound_s   = 1'b0;
    bestIdx_s   = {IDX_W{1'b0}};
    bestQ_s     = {WORD_WIDTH{1'b0}};
    bestHops_s  = {WORD_WIDTH{1'b0}};
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (cand_s[i] && (tabId_r[i] == chosenCH)) begin
        chFound_s = 1'b1;
      end else begin
      end
      if (cand_s[i] && (!bestFound_s || (tabQ_r[i] > bestQ_s) ||
                        ((tabQ_r[i] == bestQ_s) && (tabHops_r[i] < bestHops_s)))) begin
        bestFound_s = 1'b1;
        bestIdx_s   = IDX_W'(i);
        bestQ_s     = tabQ_r[i];
        bestHops_s  = tabHops_r[i];
      end else begin
      end
    end
    if (iAmDestination) begin
      selHop_s = {WORD_WIDTH{1'b0}};
    end else if (chFound_s) begin
      selHop_s = chosenCH;
    end else if (bestFound_s) begin
      selHop_s = tabId_r[bestIdx_s];
    end else begin
      selHop_s = chosenCH;
    end
  end

  // Packet field capture on the accepting edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fSrcId_r    <= {WORD_WIDTH{1'b0}};
      fSrcHops_r  <= {WORD_WIDTH{1'b0}};
      fQ_r        <= {WORD_WIDTH{1'b0}};
      fEnergy_r   <= {WORD_WIDTH{1'b0}};
      fHops_r     <= {WORD_WIDTH{1'b0}};
      fChosenCh_r <= {WORD_WIDTH{1'b0}};
      myQ_r       <= {WORD_WIDTH{1'b0}};
    end else if (take_s) begin
      fSrcId_r    <= fSourceID;
      fSrcHops_r  <= fSourceHops;
      fQ_r        <= fQValue;
      fEnergy_r   <= fEnergyLeft;
      fHops_r     <= fHopsFromCH;
      fChosenCh_r <= fChosenCH;
      myQ_r       <= myQValue;
    end else begin
    end
  end

  // Table payload storage; validity is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if ((state_r == WRITE) && accept_s && !HB_Reset) begin
      tabId_r[wrIdx_s]     <= fSrcId_r;
      tabHops_r[wrIdx_s]   <= fHops_r;
      tabEnergy_r[wrIdx_s] <= fEnergy_r;
      tabQ_r[wrIdx_s]      <= fQ_r;
    end else begin
    end
  end

  // Control FSM, valid bits and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r      <= IDLE;
      clrCnt_r     <= 6'd0;
      valid_r      <= {TABLE_DEPTH{1'b0}};
      nodeId_r     <= {WORD_WIDTH{1'b0}};
      nodeHops_r   <= {WORD_WIDTH{1'b0}};
      nodeEnergy_r <= {WORD_WIDTH{1'b0}};
      nodeQ_r      <= {WORD_WIDTH{1'b0}};
      nbrIdx_r     <= {IDX_W{1'b0}};
      chosenHop_r  <= {WORD_WIDTH{1'b0}};
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (HB_Reset) begin
        state_r  <= CLEAR;
        clrCnt_r <= 6'd0;
      end else begin
        case (state_r)
          IDLE: begin
            if (take_s) state_r <= WRITE;
            else        state_r <= IDLE;
          end
          CLEAR: begin
            // Bit 5 of the counter marks that all 32 valid bits have been wiped.
            if (clrCnt_r[5]) begin
              state_r      <= DONE;
              done_r       <= 1'b1;
              chosenHop_r  <= {WORD_WIDTH{1'b0}};
              nodeId_r     <= {WORD_WIDTH{1'b0}};
              nodeHops_r   <= {WORD_WIDTH{1'b0}};
              nodeEnergy_r <= {WORD_WIDTH{1'b0}};
              nodeQ_r      <= {WORD_WIDTH{1'b0}};
              nbrIdx_r     <= {IDX_W{1'b0}};
            end else begin
              valid_r[clrCnt_r[4:0]] <= 1'b0;
              clrCnt_r               <= clrCnt_r + 6'd1;
            end
          end
          WRITE: begin
            if (accept_s) begin
              valid_r[wrIdx_s] <= 1'b1;
              nodeId_r         <= fSrcId_r;
              nodeHops_r       <= fHops_r;
              nodeEnergy_r     <= fEnergy_r;
              nodeQ_r          <= fQ_r;
              nbrIdx_r         <= wrIdx_s;
            end else begin
            end
            state_r <= SELECT;
          end
          SELECT: begin
            chosenHop_r <= selHop_s;
            done_r      <= 1'b1;
            state_r     <= DONE;
          end
          DONE: begin
            if (take_s) state_r <= WRITE;
            else        state_r <= IDLE;
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign nodeID        = nodeId_r;
  assign nodeHops      = nodeHops_r;
  assign nodeEnergy    = nodeEnergy_r;
  assign nodeQValue    = nodeQ_r;
  assign neighborIndex = nbrIdx_r;
  assign chosenHop     = chosenHop_r;
  assign QTUFMB_done   = done_r;

endmodule

// File: tb/tb_qtu_fmb.sv
// Self-checking bench for qtu_fmb: directed steps plus randomized packets against a table-level reference model.
module tb_qtu_fmb;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic        iAmDestination = 1'b0;
  logic        HB_Reset = 1'b0;
  logic [15:0] fSourceID = 16'd0, fSourceHops = 16'd0, fQValue = 16'd0, fEnergyLeft = 16'd0;
  logic [15:0] fHopsFromCH = 16'd0, fChosenCH = 16'd0, chosenCH = 16'd0, hopsFromCH = 16'd0, myQValue = 16'd0;
  logic [15:0] nodeID, nodeHops, nodeEnergy, nodeQValue, chosenHop;
  logic [4:0]  neighborIndex;
  logic        QTUFMB_done;

  int total = 0;
  int bad = 0;

  // Reference model state
  bit          mValid [32];
  logic [15:0] mId [32], mHops [32], mEn [32], mQ [32];
  logic [15:0] expId = 16'd0, expHops = 16'd0, expEn = 16'd0, expQ = 16'd0, expHop = 16'd0;
  logic [4:0]  expIdx = 5'd0;

  qtu_fmb dut (
    .clk(clk), .nrst(nrst), .en(en), .iAmDestination(iAmDestination), .HB_Reset(HB_Reset),
    .fSourceID(fSourceID), .fSourceHops(fSourceHops), .fQValue(fQValue), .fEnergyLeft(fEnergyLeft),
    .fHopsFromCH(fHopsFromCH), .fChosenCH(fChosenCH), .chosenCH(chosenCH), .hopsFromCH(hopsFromCH),
    .myQValue(myQValue), .nodeID(nodeID), .nodeHops(nodeHops), .nodeEnergy(nodeEnergy),
    .nodeQValue(nodeQValue), .neighborIndex(neighborIndex), .chosenHop(chosenHop),
    .QTUFMB_done(QTUFMB_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mValid[i] = 1'b0;
    expId = 16'd0; expHops = 16'd0; expEn = 16'd0; expQ = 16'd0; expIdx = 5'd0; expHop = 16'd0;
  endtask

  function automatic int mFind(input logic [15:0] id);
    int low;
    for (int i = 0; i < 32; i++) if (mValid[i] && mId[i] == id) return i;
    for (int i = 0; i < 32; i++) if (!mValid[i]) return i;
    low = 0;
    for (int i = 1; i < 32; i++) if (mQ[i] < mQ[low]) low = i;
    return low;
  endfunction

  // Rank candidates by a single composite key: higher Q, then fewer hops, then lower index.
  function automatic logic [15:0] mSelect(input logic [15:0] ch, input logic [15:0] myHops, input logic dest);
    logic [47:0] key, bestKey;
    logic [15:0] bestId;
    bit          found;
    if (dest) return 16'h0000;
    found = 1'b0; bestKey = 48'd0; bestId = ch;
    for (int i = 0; i < 32; i++) begin
      if (!mValid[i]) continue;
      if (mId[i] == ch) return ch;
`ifdef QTU_FMB_HOPFILTER_EN
      if (!(mHops[i] < myHops)) continue;
`endif
      key = {mQ[i], 16'hFFFF - mHops[i], 16'(31 - i)};
      if (!found || key > bestKey) begin
        found = 1'b1; bestKey = key; bestId = mId[i];
      end
    end
    return found ? bestId : ch;
  endfunction

  task automatic checkNode(input string tag);
    chk({tag, "_id"}, nodeID, expId);
    chk({tag, "_hops"}, nodeHops, expHops);
    chk({tag, "_energy"}, nodeEnergy, expEn);
    chk({tag, "_q"}, nodeQValue, expQ);
    chk({tag, "_idx"}, neighborIndex, expIdx);
  endtask

  task automatic sendPkt(input logic [15:0] id, input logic [15:0] hops, input logic [15:0] q,
                         input logic [15:0] energy, input logic [15:0] fch);
    int w;
    fSourceID = id; fHopsFromCH = hops; fQValue = q; fEnergyLeft = energy; fChosenCH = fch;
    fSourceHops = 16'($urandom); myQValue = 16'($urandom);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    // Scramble the inputs so that only the captured copy can be used.
    fSourceID = 16'($urandom); fHopsFromCH = 16'($urandom); fQValue = 16'($urandom);
    fEnergyLeft = 16'($urandom); fChosenCH = 16'($urandom);
    if (fch == chosenCH || id == chosenCH) begin
      w = mFind(id);
      mValid[w] = 1'b1; mId[w] = id; mHops[w] = hops; mEn[w] = energy; mQ[w] = q;
      expId = id; expHops = hops; expEn = energy; expQ = q; expIdx = 5'(w);
    end
    @(posedge clk); #1;
    checkNode("wr");
    chk("wr_done_low", QTUFMB_done, 1'b0);
    expHop = mSelect(chosenCH, hopsFromCH, iAmDestination);
    @(posedge clk); #1;
    chk("sel_done", QTUFMB_done, 1'b1);
    chk("sel_hop", chosenHop, expHop);
  endtask

  task automatic hbRound();
    bit early;
    early = 1'b0;
    HB_Reset = 1'b1;
    @(posedge clk); #1;
    HB_Reset = 1'b0;
    for (int i = 0; i < 32; i++) mValid[i] = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (c == 5) begin
        fSourceID = 16'd777; fChosenCH = chosenCH; en = 1'b1;
      end
      @(posedge clk); #1;
      en = 1'b0;
      if (QTUFMB_done) early = 1'b1;
    end
    chk("hb_early_done", early, 1'b0);
    @(posedge clk); #1;
    expId = 16'd0; expHops = 16'd0; expEn = 16'd0; expQ = 16'd0; expIdx = 5'd0; expHop = 16'd0;
    chk("hb_done", QTUFMB_done, 1'b1);
    chk("hb_hop", chosenHop, 16'd0);
    checkNode("hb");
    @(posedge clk); #1;
    chk("hb_done_pulse", QTUFMB_done, 1'b0);
  endtask

  initial begin
    int lowIdx;
    int r;
    logic [15:0] id;
    modelReset();
    #12;
    checkNode("rst");
    chk("rst_hop", chosenHop, 16'd0);
    chk("rst_done", QTUFMB_done, 1'b0);
    nrst = 1'b1;
    @(posedge clk); #1;

    hbRound();

    chosenCH = 16'd25; hopsFromCH = 16'd2;
    sendPkt(16'd41, 16'd1, 16'h3000, 16'h1111, 16'd41);
    chk("rej_nodeid", nodeID, 16'd0);
    chk("rej_hop", chosenHop, 16'd25);

    sendPkt(16'd65, 16'd2, 16'h0C00, 16'h3333, 16'd25);
    chk("first_id", nodeID, 16'd65);
    chk("first_idx", neighborIndex, 5'd0);
`ifdef QTU_FMB_HOPFILTER_EN
    chk("first_hop", chosenHop, 16'd25);
`else
    chk("first_hop", chosenHop, 16'd65);
`endif

    sendPkt(16'd65, 16'd2, 16'h2000, 16'h3000, 16'd25);
    chk("upd_idx", neighborIndex, 5'd0);
    sendPkt(16'd70, 16'd2, 16'h1000, 16'h2000, 16'd25);
    chk("new_idx", neighborIndex, 5'd1);
`ifdef QTU_FMB_HOPFILTER_EN
    chk("upd_hop", chosenHop, 16'd25);
`else
    chk("upd_hop", chosenHop, 16'd65);
`endif

    // Fill the remaining 30 slots, then force a lowest-Q replacement.
    for (int i = 0; i < 30; i++)
      sendPkt(16'(100 + i), 16'($urandom_range(0, 3)), 16'($urandom_range(16'h0100, 16'h3FFF)),
              16'($urandom), 16'd25);
    lowIdx = 0;
    for (int i = 1; i < 32; i++) if (mQ[i] < mQ[lowIdx]) lowIdx = i;
    sendPkt(16'd200, 16'd1, 16'hFFFF, 16'h1234, 16'd25);
    chk("full_replace_idx", neighborIndex, 5'(lowIdx));
    chk("full_best_hop", chosenHop, 16'd200);

    // Randomized traffic from a small ID pool, occasional heartbeats and destination mode.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        hbRound();
      end else begin
        iAmDestination = ($urandom_range(0, 7) == 0);
        id = ($urandom_range(0, 6) == 0) ? 16'd25 : 16'(300 + $urandom_range(0, 9));
        sendPkt(id, 16'($urandom_range(0, 4)), 16'($urandom_range(0, 3)) << 12,
                16'($urandom), ($urandom_range(0, 3) == 0) ? 16'd26 : 16'd25);
      end
    end
    iAmDestination = 1'b0;

    // Reset while in SELECT aborts without a done pulse.
    fSourceID = 16'd88; fChosenCH = 16'd25; fQValue = 16'h0800; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b0;
    #1;
    modelReset();
    checkNode("abort");
    chk("abort_hop", chosenHop, 16'd0);
    chk("abort_done", QTUFMB_done, 1'b0);
    @(posedge clk); #1;
    chk("abort_no_done", QTUFMB_done, 1'b0);
    nrst = 1'b1;
    @(posedge clk); #1;
    hbRound();
    sendPkt(16'd25, 16'd0, 16'h0400, 16'h0100, 16'd99);
    chk("post_abort_idx", neighborIndex, 5'd0);
    chk("post_abort_hop", chosenHop, 16'd25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
